// File: rtl/rej_uniform_sampler.sv
// rtl/rej_uniform_sampler.sv - Kyber rejection sampler turning SHAKE128 squeeze blocks into N coefficients mod Q
module rej_uniform_sampler #(
  parameter int R = 1344,
  parameter int Q = 3329,
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [R-1:0] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [11:0]  coef_out,
  output logic [7:0]   coef_idx,
  output logic         coef_valid,
  input  logic         coef_ready,
  output logic         busy,
  output logic         done
);

  localparam int NCAND = 2 * R / 24;
  localparam int CW    = $clog2(NCAND);
  localparam int BW    = $clog2(R);
  localparam int KW    = $clog2(N + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [R-1:0]  block_reg;
  logic [CW-1:0] cidx;
  logic [KW-1:0] count;

  logic [BW-1:0] tri_base;
  logic [23:0]   triple;
  logic [11:0]   cand;
  logic          accept;
  logic          last_cand;
  logic          xfer;
  logic          fill_done;

  // Two 12-bit candidates share each 3-byte group; cidx[0] picks the half.
  assign tri_base  = BW'(cidx >> 1) * BW'(24);
  assign triple    = block_reg[tri_base +: 24];
  assign cand      = cidx[0] ? {triple[23:16], triple[15:12]} : {triple[11:8], triple[7:0]};
  assign accept    = (state == S_SAMPLE) && (cand < 12'(Q));
  assign last_cand = (cidx == CW'(NCAND - 1));
  assign xfer      = accept && coef_ready;
  assign fill_done = (count == KW'(N - 1));

  assign block_ready = (state == S_WAIT);
  assign coef_valid  = accept;
  assign coef_out    = accept ? cand : 12'd0;
  assign coef_idx    = accept ? 8'(count) : 8'd0;
  assign busy        = (state == S_WAIT) || (state == S_SAMPLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      block_reg <= '0;
      cidx      <= '0;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_WAIT;
            count <= '0;
          end
        end
        S_WAIT: begin
          if (block_valid) begin
            block_reg <= block_in;
            cidx      <= '0;
            state     <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          // A stalled accepted candidate freezes everything; rejects always advance.
          if (!accept || coef_ready) begin
            cidx <= cidx + CW'(1);
            if (xfer) count <= count + KW'(1);
            if (xfer && fill_done) state <= S_DONE;
            else if (last_cand)    state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// tb/tb_rej_uniform_sampler.sv - self-checking bench for rej_uniform_sampler
module tb_rej_uniform_sampler;

  localparam int R      = 1344;
  localparam int Q      = 3329;
  localparam int N      = 256;
  localparam int NB     = 16;
  localparam int NBYTES = R / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [R-1:0]  block_in;
  logic          block_valid;
  logic          block_ready;
  logic [11:0]   coef_out;
  logic [7:0]    coef_idx;
  logic          coef_valid;
  logic          coef_ready;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  logic [R-1:0] blocks [NB];
  int           exp_q [$];

  typedef struct {
    logic [7:0] b0, b1, b2;
    bit         v0;
    int         d0;
    bit         v1;
    int         d1;
  } vec_t;
  vec_t tv [8];

  rej_uniform_sampler #(.R(R), .Q(Q), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .coef_out    (coef_out),
    .coef_idx    (coef_idx),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; block_valid = 1'b0; coef_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_zero();
    for (int b = 0; b < NB; b++) blocks[b] = '0;
  endtask

  task automatic fill_random();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < R / 32; w++) blocks[b][32*w +: 32] = $urandom();
  endtask

  // Reference: walk bytes three at a time, keep 12-bit values below Q until N are collected.
  function automatic int model();
    int nblk = 0;
    exp_q.delete();
    for (int b = 0; b < NB && exp_q.size() < N; b++) begin
      nblk++;
      for (int j = 0; j + 2 < NBYTES && exp_q.size() < N; j += 3) begin
        int x0 = int'(blocks[b][8*j +: 8]);
        int x1 = int'(blocks[b][8*(j+1) +: 8]);
        int x2 = int'(blocks[b][8*(j+2) +: 8]);
        int d0 = x0 + 256 * (x1 % 16);
        int d1 = x1 / 16 + 16 * x2;
        if (d0 < Q) exp_q.push_back(d0);
        if (d1 < Q && exp_q.size() < N) exp_q.push_back(d1);
      end
    end
    return nblk;
  endfunction

  // mode 0: always ready; 1: random valid/ready; 2: stall at coef 50 + start at coef 100; 3: stop after coef 100
  task automatic run_poly(input int mode, input int exp_nblk_in);
    int k = 0;
    int ptr = 0;
    int stall = 0;
    int exp_nblk;
    bit start_sent = 0;
    bit held = 0;
    logic [11:0] h_out;
    logic [7:0]  h_idx;
    exp_nblk = model();
    if (exp_nblk_in >= 0) exp_nblk = exp_nblk_in;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      if (cyc > 0 && done) break;
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", block_ready, 1);
      end
      block_in    = blocks[(ptr < NB) ? ptr : NB - 1];
      block_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && k == 50 && stall < 10) begin
        coef_ready = 1'b0;
        if (coef_valid) begin
          if (!held) begin
            h_out = coef_out; h_idx = coef_idx; held = 1;
          end else begin
            chk("stall_out", coef_out, h_out);
            chk("stall_idx", coef_idx, h_idx);
          end
          stall++;
        end
      end
      if (mode == 2 && k == 100 && !start_sent && cyc > 0) begin
        start = 1'b1;
        start_sent = 1;
      end
      if (coef_valid && coef_ready) begin
        chk("coef_idx", coef_idx, k & 255);
        chk("coef_out", coef_out, (k < exp_q.size()) ? exp_q[k] : -1);
        k++;
      end
      if (block_valid && block_ready) ptr++;
      @(posedge clk);
      if (mode == 3 && k == 100) return;
    end
    start = 1'b0; block_valid = 1'b0; coef_ready = 1'b1;
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", coef_valid, 0);
    chk("coef_count", k, N);
    chk("block_handshakes", ptr, exp_nblk);
  endtask

  initial begin
    int gap;
    bit seen;
    logic [R-1:0] blk;

    tv[0] = '{8'h01, 8'h23, 8'h45, 1'b1, 769,  1'b1, 1106};
    tv[1] = '{8'h01, 8'h0D, 8'hD0, 1'b0, 3329, 1'b1, 3328};
    tv[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 4095, 1'b0, 4095};
    tv[3] = '{8'h00, 8'h00, 8'h00, 1'b1, 0,    1'b1, 0};
    tv[4] = '{8'h00, 8'h0D, 8'h00, 1'b1, 3328, 1'b1, 0};
    tv[5] = '{8'hFF, 8'h0C, 8'hCF, 1'b1, 3327, 1'b1, 3312};
    tv[6] = '{8'h00, 8'hF0, 8'hFF, 1'b1, 0,    1'b0, 4095};
    tv[7] = '{8'h02, 8'h1D, 8'hD0, 1'b0, 3330, 1'b0, 3329};

    rst = 1'b1; start = 1'b0; block_valid = 1'b0; coef_ready = 1'b0; block_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_block_ready", block_ready, 0);
    chk("reset_coef_valid", coef_valid, 0);
    chk("reset_coef_out", coef_out, 0);
    chk("reset_coef_idx", coef_idx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      do_reset();
      blk = '0;
      blk[23:0] = {tv[i].b2, tv[i].b1, tv[i].b0};
      start = 1'b1; block_in = blk; coef_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; block_valid = 1'b1;
      chk("tv_block_ready", block_ready, 1);
      @(negedge clk);
      block_valid = 1'b0;
      chk("tv_valid0", coef_valid, int'(tv[i].v0));
      if (tv[i].v0) begin
        chk("tv_out0", coef_out, tv[i].d0);
        chk("tv_idx0", coef_idx, 0);
      end
      @(negedge clk);
      chk("tv_valid1", coef_valid, int'(tv[i].v1));
      if (tv[i].v1) begin
        chk("tv_out1", coef_out, tv[i].d1);
        chk("tv_idx1", coef_idx, tv[i].v0 ? 1 : 0);
      end
    end

    // All-0xFF block: no output, next block requested after every candidate is scanned
    do_reset();
    start = 1'b1; block_in = '1; coef_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; block_valid = 1'b1;
    chk("ff_block_ready", block_ready, 1);
    @(negedge clk);
    block_valid = 1'b0;
    chk("ff_busy", busy, 1);
    gap = 0; seen = 0;
    while (!block_ready && gap < 300) begin
      if (coef_valid) seen = 1;
      @(negedge clk);
      gap++;
    end
    chk("ff_gap", gap, 112);
    chk("ff_no_coef", seen, 0);

    do_reset();
    fill_zero();
    blocks[0][23:0] = 24'h452301;
    run_poly(0, 3);

    fill_zero();
    blocks[0][23:0] = 24'hD00D01;
    run_poly(0, -1);

    fill_random();
    run_poly(2, -1);
    fill_random();
    run_poly(0, -1);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_poly(1, -1);
    end

    fill_random();
    run_poly(3, -1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_block_ready", block_ready, 0);
    chk("rst_mid_coef_valid", coef_valid, 0);
    chk("rst_mid_coef_out", coef_out, 0);
    chk("rst_mid_coef_idx", coef_idx, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    start = 1'b0; block_valid = 1'b0; coef_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", coef_valid, 0);
    chk("post_rst_busy", busy, 0);
    fill_random();
    run_poly(0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
